// File: rtl/seq_game_pkg.sv
// Shared types and constants for the sequence game.
// The sequence_input capture stage uses seq_in_state_t and SEQ_LEN_DEFAULT.
package seq_game_pkg;

    localparam int SEQ_LEN_DEFAULT = 8;
    localparam int SEQ_LEN_MIN     = 2;
    localparam int SEQ_LEN_MAX     = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } seq_in_state_t;

    // Width of a 0..n counter.
    function automatic int count_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Single-cycle pulse on each rising edge of a debounced level input.
// Reusable for any button in the game.
module rise_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic in_q;

    // in_q resets to 0, so a level held high across reset yields one pulse after release.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign pulse = in & ~in_q;

endmodule

// File: rtl/sequence_input.sv
// Captures the player's guess bit by bit on enter-button presses and holds it for the checker.
// Optional idle timeout on partial guesses is compiled in with SEQ_INPUT_TIMEOUT_EN.
module sequence_input
    import seq_game_pkg::*;
#(
    parameter int SEQ_LEN        = SEQ_LEN_DEFAULT,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    localparam int CW            = $clog2(SEQ_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sw,
    input  logic               btn,
    input  logic               clear,
    input  logic               ack,
    output logic [SEQ_LEN-1:0] user_sequence,
    output logic               seq_valid,
    output logic [CW-1:0]      bit_count,
    output logic               timeout
);

    // Handshake: seq_valid is held high with user_sequence stable until ack is seen
    // while valid; the guess is released on the edge that samples ack. ack without
    // seq_valid has no effect.

    seq_in_state_t      state, state_next;
    logic [SEQ_LEN-1:0] seq_next;
    logic [CW-1:0]      cnt_next;
    logic               valid_next;
    logic               timeout_next;
    logic               press;
    logic               expired;
    logic               last_bit;

    rise_edge_detect u_press (
        .clk   (clk),
        .reset (reset),
        .in    (btn),
        .pulse (press)
    );

    assign last_bit = (bit_count == CW'(SEQ_LEN - 1));

`ifdef SEQ_INPUT_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] idle_cnt, idle_cnt_next;

    assign expired = (state == COLLECT) && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Counts only while staying in COLLECT without a press; anything else restarts it.
    always_comb begin
        idle_cnt_next = '0;
        if (state == COLLECT && state_next == COLLECT && !press) begin
            idle_cnt_next = idle_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt_next;
        end
    end
`else
    localparam int timeout_cycles_unused = TIMEOUT_CYCLES;

    assign expired = 1'b0;
`endif

    always_comb begin
        state_next   = state;
        seq_next     = user_sequence;
        cnt_next     = bit_count;
        timeout_next = 1'b0;

        if (clear) begin
            state_next = IDLE;
            seq_next   = '0;
            cnt_next   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (press) begin
                        seq_next   = {user_sequence[SEQ_LEN-2:0], sw};
                        cnt_next   = bit_count + CW'(1);
                        state_next = COLLECT;
                    end
                end
                COLLECT: begin
                    if (expired) begin
                        state_next   = IDLE;
                        seq_next     = '0;
                        cnt_next     = '0;
                        timeout_next = 1'b1;
                    end else if (press) begin
                        seq_next = {user_sequence[SEQ_LEN-2:0], sw};
                        cnt_next = bit_count + CW'(1);
                        if (last_bit) begin
                            state_next = FULL;
                        end
                    end
                end
                FULL: begin
                    // Presses are ignored until the consumer takes the guess.
                    if (ack) begin
                        state_next = IDLE;
                        seq_next   = '0;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    seq_next   = '0;
                    cnt_next   = '0;
                end
            endcase
        end

        valid_next = (state_next == FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            user_sequence <= '0;
            bit_count     <= '0;
            seq_valid     <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            state         <= state_next;
            user_sequence <= seq_next;
            bit_count     <= cnt_next;
            seq_valid     <= valid_next;
            timeout       <= timeout_next;
        end
    end

endmodule

// File: tb/tb_sequence_input.sv
// Directed bench for sequence_input; completed guesses go through an expected queue.
// Build with SEQ_INPUT_TIMEOUT_EN to exercise the 16-cycle timeout path.
module tb_sequence_input;
    import seq_game_pkg::*;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);
`ifdef SEQ_INPUT_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 50_000_000;
`endif

    logic          clk = 1'b0;
    logic          reset, sw, btn, clear, ack;
    logic [W-1:0]  user_sequence;
    logic          seq_valid;
    logic [CW-1:0] bit_count;
    logic          timeout;

    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  exp_seq;
    int            exp_cnt;
    bit            exp_full;
    bit            valid_seen;
    int            n_checks = 0;
    int            n_fail   = 0;

    sequence_input #(
        .SEQ_LEN        (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sw            (sw),
        .btn           (btn),
        .clear         (clear),
        .ack           (ack),
        .user_sequence (user_sequence),
        .seq_valid     (seq_valid),
        .bit_count     (bit_count),
        .timeout       (timeout)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_seq    = '0;
        exp_cnt    = 0;
        exp_full   = 1'b0;
        valid_seen = 1'b0;
    endtask

    // Pop the queued guess the first time the DUT raises seq_valid.
    task automatic scoreboard_sample();
        if (seq_valid === 1'b1 && !valid_seen) begin
            valid_seen = 1'b1;
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected_valid observed=%0h expected=empty", user_sequence);
            end
            if (exp_q.size() > 0) begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("sb_guess", user_sequence, e);
            end
        end
    endtask

    // One full button press: high for a cycle, then low for a cycle.
    task automatic press(input logic s);
        sw  = s;
        btn = 1'b1;
        tick();
        if (!exp_full) begin
            exp_seq = {exp_seq[W-2:0], s};
            exp_cnt++;
            if (exp_cnt == W) begin
                exp_full = 1'b1;
                exp_q.push_back(exp_seq);
            end
        end
        check("press_cnt", bit_count, exp_cnt);
        check("press_seq", user_sequence, exp_seq);
        check("press_valid", seq_valid, exp_full);
        scoreboard_sample();
        btn = 1'b0;
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_reset();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_seq"}, user_sequence, 0);
        check({tag, "_valid"}, seq_valid, 0);
        check({tag, "_cnt"}, bit_count, 0);
        check({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin
        logic [7:0] pattern;
        int         max_cnt;
        int         k;
        bit         seen;

        reset = 1'b1; sw = 1'b0; btn = 1'b0; clear = 1'b0; ack = 1'b0;
        model_reset();
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Main guess 1,0,1,1,0,0,1,0 -> B2
        pattern = 8'b1011_0010;
        for (int i = 7; i >= 0; i--) press(pattern[i]);
        check("full_literal", user_sequence, 8'hB2);
        check("full_cnt_literal", bit_count, 8);

        // Presses in FULL are ignored
        press(1'b1); press(1'b1); press(1'b0);
        check("full_hold_seq", user_sequence, 8'hB2);
        check("full_hold_valid", seq_valid, 1);

        // ack with a simultaneous press: guess released, press lost
        ack = 1'b1; btn = 1'b1; sw = 1'b1;
        tick();
        ack = 1'b0; btn = 1'b0;
        model_reset();
        check_all_zero("ack");
        tick();
        check("ack_press_lost", bit_count, 0);

        // ack outside FULL is ignored
        press(1'b1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ack_idle_cnt", bit_count, 1);
        check("ack_idle_seq", user_sequence, 1);
        do_clear();

        // clear in the same cycle as the 4th press
        press(1'b1); press(1'b1); press(1'b1);
        clear = 1'b1; btn = 1'b1; sw = 1'b1;
        tick();
        clear = 1'b0; btn = 1'b0;
        model_reset();
        check_all_zero("clear");
        tick();
        check("clear_press_lost", bit_count, 0);

        // btn held high for 20 cycles counts once
        sw = 1'b1; btn = 1'b1; max_cnt = 0;
        repeat (20) begin
            tick();
            if (int'(bit_count) > max_cnt) max_cnt = int'(bit_count);
        end
        check("hold_max_cnt", max_cnt, 1);
        btn = 1'b0;
        tick();
        do_clear();

        // Idle after 2 presses
        press(1'b1); press(1'b0);
`ifdef SEQ_INPUT_TIMEOUT_EN
        k = 1; seen = 1'b0;
        while (k < 40 && !seen) begin
            tick();
            k++;
            if (timeout === 1'b1) seen = 1'b1;
        end
        check("to_seen", seen, 1);
        check("to_delay", k, 16);
        check("to_cnt", bit_count, 0);
        check("to_seq", user_sequence, 0);
        tick();
        check("to_pulse_width", timeout, 0);
        model_reset();
`else
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (timeout !== 1'b0) seen = 1'b1;
        end
        check("no_to_pulse", seen, 0);
        check("no_to_cnt", bit_count, 2);
        check("no_to_seq", user_sequence, 2);
        do_clear();
`endif

        // Reset mid-collection, then a fresh random guess
        for (int i = 0; i < 5; i++) press(1'b1);
        reset = 1'b1;
        tick();
        check_all_zero("midreset");
        reset = 1'b0;
        model_reset();
        tick();
        for (int i = 0; i < W; i++) press(logic'($urandom_range(0, 1)));
        check("fresh_valid", seq_valid, 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        model_reset();
        check_all_zero("fresh_ack");

        // btn held across reset release gives exactly one press
        btn = 1'b1; sw = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("btn_reset_cnt", bit_count, 1);
        tick();
        check("btn_reset_cnt_hold", bit_count, 1);
        btn = 1'b0;
        tick();
        do_clear();

        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
